host_rd_arbiter: RTL and testbench

- Shares the single AXI4 host-memory read channel (AR/R) between ENGINE_NUM engine kernels in the multi-process action framework.
- Round-robin arbitration of engine AR requests into one registered AR output slot.
- Tags ARID with the engine index and demultiplexes R beats back to engines by RID.
- Enforces a per-engine outstanding-burst limit.

---
 rtl/host_rd_arb_pkg.sv | 41 ++++
 rtl/host_rd_arbiter_rr_arbiter.sv | 29 ++
 rtl/host_rd_arbiter.sv | 222 ++++++++++++++++++++++
 tb/tb_host_rd_arbiter.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/host_rd_arb_pkg.sv
// Shared constants and the round-robin search helper for host_rd_arbiter.
// The top's optional perf counters are enabled with HOST_RD_ARB_PERF_EN.
package host_rd_arb_pkg;

  localparam logic [2:0] AXSIZE_64B   = 3'b110;
  localparam logic [1:0] AXBURST_INCR = 2'b01;

  // Widest request vector the search helper handles.
  localparam int unsigned RR_MAX_N = 16;
  localparam int unsigned RR_IDX_W = 4;

  localparam int unsigned DEF_MAX_OUTSTANDING = 4;
  localparam int unsigned OUTST_W = $clog2(DEF_MAX_OUTSTANDING + 1);

  function automatic int unsigned outst_width(input int unsigned max_outst);
    return $clog2(max_outst + 1);
  endfunction

  typedef struct packed {
    logic                found;
    logic [RR_IDX_W-1:0] idx;
  } rr_pick_t;

  // First set bit of req[0..n-1] at or after ptr, wrapping n-1 -> 0.
  function automatic rr_pick_t rr_next_grant(input logic [RR_MAX_N-1:0] req,
                                             input logic [RR_IDX_W-1:0] ptr,
                                             input int unsigned         n);
    rr_pick_t    res;
    int unsigned j;
    res = '0;
    for (int unsigned k = 0; k < RR_MAX_N; k++) begin
      j = (32'(ptr) + k) % n;
      if ((k < n) && !res.found && req[RR_IDX_W'(j)]) begin
        res.found = 1'b1;
        res.idx   = RR_IDX_W'(j);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/host_rd_arbiter_rr_arbiter.sv
// Round-robin arbiter: request vector and pointer in, one-hot grant plus
// encoded index out. Purely combinational; the caller owns the pointer.
module rr_arbiter
  import host_rd_arb_pkg::*;
#(
  parameter int unsigned N     = 8,
  parameter int unsigned IDX_W = 3
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  input  logic             en_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] gnt_idx_o,
  output logic             gnt_valid_o
);

  rr_pick_t pick;

  always_comb begin
    pick        = rr_next_grant(RR_MAX_N'(req_i), RR_IDX_W'(ptr_i), N);
    gnt_valid_o = en_i && pick.found;
    gnt_idx_o   = IDX_W'(pick.idx);
    gnt_o       = '0;
    for (int unsigned i = 0; i < N; i++) begin
      gnt_o[i] = gnt_valid_o && (pick.idx == RR_IDX_W'(i));
    end
  end

endmodule

// File: rtl/host_rd_arbiter.sv
// Shares one AXI4 host read channel between ENGINE_NUM engines: round-robin AR
// grant into a registered slot, ARID = engine index, R demux by RID.
// Optional grant/stall counters: define HOST_RD_ARB_PERF_EN.
module host_rd_arbiter
  import host_rd_arb_pkg::*;
#(
  parameter int unsigned ENGINE_NUM      = 8,
  parameter int unsigned ENG_IDX_W       = 3,
  parameter int unsigned ID_WIDTH        = 5,
  parameter int unsigned ADDR_WIDTH      = 64,
  parameter int unsigned DATA_WIDTH      = 512,
  parameter int unsigned MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [ENGINE_NUM-1:0]            eng_arvalid,
  output logic [ENGINE_NUM-1:0]            eng_arready,
  input  logic [ENGINE_NUM*ADDR_WIDTH-1:0] eng_araddr,
  input  logic [ENGINE_NUM*8-1:0]          eng_arlen,
  output logic [ENGINE_NUM-1:0]            eng_rvalid,
  input  logic [ENGINE_NUM-1:0]            eng_rready,
  output logic [DATA_WIDTH-1:0]            eng_rdata,
  output logic [1:0]                       eng_rresp,
  output logic                             eng_rlast,
  output logic [ID_WIDTH-1:0]              m_axi_arid,
  output logic [ADDR_WIDTH-1:0]            m_axi_araddr,
  output logic [7:0]                       m_axi_arlen,
  output logic [2:0]                       m_axi_arsize,
  output logic [1:0]                       m_axi_arburst,
  output logic                             m_axi_arvalid,
  input  logic                             m_axi_arready,
  input  logic [ID_WIDTH-1:0]              m_axi_rid,
  input  logic [DATA_WIDTH-1:0]            m_axi_rdata,
  input  logic [1:0]                       m_axi_rresp,
  input  logic                             m_axi_rlast,
  input  logic                             m_axi_rvalid,
  output logic                             m_axi_rready,
  output logic                             o_rid_err,
  output logic                             o_busy
`ifdef HOST_RD_ARB_PERF_EN
  , output logic [ENGINE_NUM*32-1:0]       o_grant_cnt
  , output logic [31:0]                    o_stall_cnt
`endif
);

  // Handshakes: a transfer happens on a rising clk edge where valid && ready.
  // Once raised, valid and its payload stay stable until that edge.

  localparam int unsigned           CNT_W     = outst_width(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0]      CNT_MAX   = CNT_W'(MAX_OUTSTANDING);
  localparam logic [ENG_IDX_W:0]    ENG_NUM_X = (ENG_IDX_W + 1)'(ENGINE_NUM);
  localparam logic [ENG_IDX_W-1:0]  LAST_ENG  = ENG_IDX_W'(ENGINE_NUM - 1);

  logic                  ar_valid_q, ar_valid_d;
  logic [ID_WIDTH-1:0]   ar_id_q, ar_id_d;
  logic [ADDR_WIDTH-1:0] ar_addr_q, ar_addr_d;
  logic [7:0]            ar_len_q, ar_len_d;
  logic [ENG_IDX_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0]      outst_q [ENGINE_NUM];
  logic [CNT_W-1:0]      outst_d [ENGINE_NUM];
  logic                  rid_err_q, rid_err_d;

  logic [ADDR_WIDTH-1:0] eng_addr_a [ENGINE_NUM];
  logic [7:0]            eng_len_a  [ENGINE_NUM];
  logic [ENGINE_NUM-1:0] eligible;
  logic [ENGINE_NUM-1:0] gnt;
  logic [ENG_IDX_W-1:0]  gnt_idx;
  logic                  gnt_valid;
  logic                  slot_load;

  logic [ENG_IDX_W-1:0]  rid_idx;
  logic                  rid_ok;
  logic [ENGINE_NUM-1:0] r_last_hs;
  logic [ENGINE_NUM-1:0] inc_v, dec_v, outst_nz;

  always_comb begin
    for (int unsigned i = 0; i < ENGINE_NUM; i++) begin
      eng_addr_a[i] = eng_araddr[i*ADDR_WIDTH +: ADDR_WIDTH];
      eng_len_a[i]  = eng_arlen[i*8 +: 8];
      eligible[i]   = eng_arvalid[i] && (outst_q[i] < CNT_MAX);
    end
  end

  // The slot accepts a new request when empty or draining this very cycle.
  assign slot_load = !ar_valid_q || m_axi_arready;

  rr_arbiter #(
    .N     (ENGINE_NUM),
    .IDX_W (ENG_IDX_W)
  ) u_rr (
    .req_i       (eligible),
    .ptr_i       (ptr_q),
    .en_i        (slot_load && rst_n),
    .gnt_o       (gnt),
    .gnt_idx_o   (gnt_idx),
    .gnt_valid_o (gnt_valid)
  );

  assign eng_arready = gnt;

  always_comb begin
    ar_valid_d = ar_valid_q;
    ar_id_d    = ar_id_q;
    ar_addr_d  = ar_addr_q;
    ar_len_d   = ar_len_q;
    ptr_d      = ptr_q;
    if (slot_load) begin
      ar_valid_d = gnt_valid;
    end
    if (gnt_valid) begin
      ar_id_d   = ID_WIDTH'(gnt_idx);
      ar_addr_d = eng_addr_a[gnt_idx];
      ar_len_d  = eng_len_a[gnt_idx];
      ptr_d     = (gnt_idx == LAST_ENG) ? '0 : gnt_idx + ENG_IDX_W'(1);
    end
  end

  // An RID is routable only if its upper bits are clear and the index exists.
  assign rid_idx = m_axi_rid[ENG_IDX_W-1:0];
  assign rid_ok  = ((m_axi_rid >> ENG_IDX_W) == '0) && ({1'b0, rid_idx} < ENG_NUM_X);

  always_comb begin
    eng_rvalid   = '0;
    r_last_hs    = '0;
    m_axi_rready = 1'b1;
    if (rid_ok) begin
      m_axi_rready = eng_rready[rid_idx];
    end
    for (int unsigned i = 0; i < ENGINE_NUM; i++) begin
      if (rid_ok && (rid_idx == ENG_IDX_W'(i))) begin
        eng_rvalid[i] = m_axi_rvalid;
        r_last_hs[i]  = m_axi_rvalid && eng_rready[i] && m_axi_rlast;
      end
    end
  end

  assign eng_rdata = m_axi_rdata;
  assign eng_rresp = m_axi_rresp;
  assign eng_rlast = m_axi_rlast;

  assign rid_err_d = rid_err_q || (m_axi_rvalid && !rid_ok);

  // A grant and a last beat for the same engine in one cycle cancel out.
  always_comb begin
    for (int unsigned i = 0; i < ENGINE_NUM; i++) begin
      outst_nz[i] = (outst_q[i] != '0);
      inc_v[i]    = gnt[i] && (outst_q[i] != CNT_MAX);
      dec_v[i]    = r_last_hs[i] && outst_nz[i];
      outst_d[i]  = outst_q[i];
      if (inc_v[i] && !dec_v[i]) begin
        outst_d[i] = outst_q[i] + CNT_W'(1);
      end else if (dec_v[i] && !inc_v[i]) begin
        outst_d[i] = outst_q[i] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ar_valid_q <= 1'b0;
      ar_id_q    <= '0;
      ar_addr_q  <= '0;
      ar_len_q   <= '0;
      ptr_q      <= '0;
      rid_err_q  <= 1'b0;
      for (int unsigned i = 0; i < ENGINE_NUM; i++) begin
        outst_q[i] <= '0;
      end
    end else begin
      ar_valid_q <= ar_valid_d;
      ar_id_q    <= ar_id_d;
      ar_addr_q  <= ar_addr_d;
      ar_len_q   <= ar_len_d;
      ptr_q      <= ptr_d;
      rid_err_q  <= rid_err_d;
      for (int unsigned i = 0; i < ENGINE_NUM; i++) begin
        outst_q[i] <= outst_d[i];
      end
    end
  end

  assign m_axi_arvalid = ar_valid_q;
  assign m_axi_arid    = ar_id_q;
  assign m_axi_araddr  = ar_addr_q;
  assign m_axi_arlen   = ar_len_q;
  assign m_axi_arsize  = AXSIZE_64B;
  assign m_axi_arburst = AXBURST_INCR;
  assign o_rid_err     = rid_err_q;
  assign o_busy        = ar_valid_q || (|outst_nz);

`ifdef HOST_RD_ARB_PERF_EN
  logic [31:0] grant_cnt_q [ENGINE_NUM];
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      for (int unsigned i = 0; i < ENGINE_NUM; i++) begin
        grant_cnt_q[i] <= '0;
      end
    end else begin
      if (ar_valid_q && !m_axi_arready) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      for (int unsigned i = 0; i < ENGINE_NUM; i++) begin
        if (gnt[i]) begin
          grant_cnt_q[i] <= grant_cnt_q[i] + 32'd1;
        end
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < ENGINE_NUM; i++) begin
      o_grant_cnt[i*32 +: 32] = grant_cnt_q[i];
    end
  end

  assign o_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_host_rd_arbiter.sv
// Directed bench for host_rd_arbiter: expected AR and R transfers are queued
// by the stimulus and popped by independent monitors.
module tb_host_rd_arbiter;

  localparam int EN  = 8;
  localparam int IW  = 3;
  localparam int IDW = 5;
  localparam int AW  = 64;
  localparam int DW  = 512;
  localparam int ARW = IDW + AW + 8;
  localparam int RW  = IW + 1 + DW;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [EN-1:0]      eng_arvalid;
  logic [EN-1:0]      eng_arready;
  logic [EN*AW-1:0]   eng_araddr;
  logic [EN*8-1:0]    eng_arlen;
  logic [EN-1:0]      eng_rvalid;
  logic [EN-1:0]      eng_rready;
  logic [DW-1:0]      eng_rdata;
  logic [1:0]         eng_rresp;
  logic               eng_rlast;
  logic [IDW-1:0]     m_axi_arid;
  logic [AW-1:0]      m_axi_araddr;
  logic [7:0]         m_axi_arlen;
  logic [2:0]         m_axi_arsize;
  logic [1:0]         m_axi_arburst;
  logic               m_axi_arvalid;
  logic               m_axi_arready;
  logic [IDW-1:0]     m_axi_rid;
  logic [DW-1:0]      m_axi_rdata;
  logic [1:0]         m_axi_rresp;
  logic               m_axi_rlast;
  logic               m_axi_rvalid;
  logic               m_axi_rready;
  logic               o_rid_err;
  logic               o_busy;
`ifdef HOST_RD_ARB_PERF_EN
  logic [EN*32-1:0]   o_grant_cnt;
  logic [31:0]        o_stall_cnt;
`endif

  host_rd_arbiter dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .eng_arvalid   (eng_arvalid),
    .eng_arready   (eng_arready),
    .eng_araddr    (eng_araddr),
    .eng_arlen     (eng_arlen),
    .eng_rvalid    (eng_rvalid),
    .eng_rready    (eng_rready),
    .eng_rdata     (eng_rdata),
    .eng_rresp     (eng_rresp),
    .eng_rlast     (eng_rlast),
    .m_axi_arid    (m_axi_arid),
    .m_axi_araddr  (m_axi_araddr),
    .m_axi_arlen   (m_axi_arlen),
    .m_axi_arsize  (m_axi_arsize),
    .m_axi_arburst (m_axi_arburst),
    .m_axi_arvalid (m_axi_arvalid),
    .m_axi_arready (m_axi_arready),
    .m_axi_rid     (m_axi_rid),
    .m_axi_rdata   (m_axi_rdata),
    .m_axi_rresp   (m_axi_rresp),
    .m_axi_rlast   (m_axi_rlast),
    .m_axi_rvalid  (m_axi_rvalid),
    .m_axi_rready  (m_axi_rready),
    .o_rid_err     (o_rid_err),
    .o_busy        (o_busy)
`ifdef HOST_RD_ARB_PERF_EN
    , .o_grant_cnt (o_grant_cnt)
    , .o_stall_cnt (o_stall_cnt)
`endif
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad = 0;
  int ar_hs_cnt = 0;
  logic [ARW-1:0] exp_ar_q[$];
  logic [RW-1:0]  exp_r_q[$];
  logic [ARW-1:0] ar_e;
  logic [RW-1:0]  r_e;
  logic [EN-1:0]  r_hs;
  int             r_eng;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_data(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [AW-1:0] addr_of(input int e);
    return 64'hC0DE_0000_0000_0000 + (64'(e) << 12);
  endfunction

  function automatic logic [7:0] len_of(input int e);
    return 8'h10 + 8'(e);
  endfunction

  function automatic logic [DW-1:0] beat_of(input int e, input int b);
    logic [63:0] w;
    w = 64'hD00D_0000_0000_0000 + (64'(e) << 8) + 64'(b);
    return {(DW / 64){w}};
  endfunction

  function automatic logic [ARW-1:0] ar_item(input int e);
    return {IDW'(e), addr_of(e), len_of(e)};
  endfunction

  function automatic logic [RW-1:0] r_item(input int e, input logic last, input logic [DW-1:0] d);
    return {IW'(e), last, d};
  endfunction

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (rst_n && m_axi_arvalid && m_axi_arready) begin
      ar_hs_cnt++;
      if (exp_ar_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL ar_unexpected: got id %0h expected no transfer", m_axi_arid);
      end else begin
        ar_e = exp_ar_q.pop_front();
        chk("ar_id", 64'(m_axi_arid), 64'(ar_e[ARW-1 -: IDW]));
        chk("ar_addr", 64'(m_axi_araddr), 64'(ar_e[AW+7:8]));
        chk("ar_len", 64'(m_axi_arlen), 64'(ar_e[7:0]));
        chk("ar_size_burst", 64'({m_axi_arsize, m_axi_arburst}), 64'({3'b110, 2'b01}));
      end
    end
  end

  always @(negedge clk) begin
    r_hs = eng_rvalid & eng_rready;
    if (rst_n && (r_hs != '0)) begin
      if (exp_r_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL r_unexpected: got rvalid %0h expected none", eng_rvalid);
      end else begin
        r_e = exp_r_q.pop_front();
        r_eng = -1;
        for (int i = 0; i < EN; i++) if (r_hs[i]) r_eng = i;
        chk("r_onehot", 64'($countones(r_hs)), 64'(1));
        chk("r_engine", 64'(r_eng), 64'(r_e[RW-1 -: IW]));
        chk("r_last", 64'(eng_rlast), 64'(r_e[DW]));
        chk_data("r_data", eng_rdata, r_e[DW-1:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle();
    eng_arvalid   = '0;
    eng_rready    = '0;
    m_axi_arready = 1'b1;
    m_axi_rid     = '0;
    m_axi_rdata   = '0;
    m_axi_rresp   = 2'b00;
    m_axi_rlast   = 1'b0;
    m_axi_rvalid  = 1'b0;
  endtask

  task automatic do_reset(input logic [EN-1:0] req_during);
    idle();
    eng_arvalid = req_during;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_arvalid", 64'(m_axi_arvalid), 64'(0));
    chk("rst_arid", 64'(m_axi_arid), 64'(0));
    chk("rst_araddr", 64'(m_axi_araddr), 64'(0));
    chk("rst_arlen", 64'(m_axi_arlen), 64'(0));
    chk("rst_eng_arready", 64'(eng_arready), 64'(0));
    chk("rst_rid_err", 64'(o_rid_err), 64'(0));
    chk("rst_busy", 64'(o_busy), 64'(0));
    @(posedge clk);
    #1;
    eng_arvalid = '0;
    rst_n = 1'b1;
  endtask

  task automatic host_beat(input logic [IDW-1:0] rid, input logic [DW-1:0] d, input logic last);
    m_axi_rid    = rid;
    m_axi_rdata  = d;
    m_axi_rlast  = last;
    m_axi_rvalid = 1'b1;
    tick(1);
    m_axi_rvalid = 1'b0;
    m_axi_rlast  = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_ar_q.size() == 0 && exp_r_q.size() == 0) break;
      tick(1);
    end
    chk(name, 64'(exp_ar_q.size() + exp_r_q.size()), 64'(0));
  endtask

  // ---------------- stimulus ----------------
  int base;
  logic hs;

  initial begin
    idle();
    for (int i = 0; i < EN; i++) begin
      eng_araddr[i*AW +: AW] = addr_of(i);
      eng_arlen[i*8 +: 8]    = len_of(i);
    end
    do_reset('1);

    // T1: all engines requesting, host always ready
    for (int k = 0; k < 9; k++) exp_ar_q.push_back(ar_item(k % EN));
    base = ar_hs_cnt;
    eng_arvalid = '1;
    @(negedge clk);
    chk("t1_first_arready", 64'(eng_arready), 64'(8'h01));
    tick(9);
    eng_arvalid = '0;
    @(negedge clk);
    #1;
    chk("t1_one_per_cycle", 64'(ar_hs_cnt - base), 64'(9));
    wait_drain("t1_drain", 20);
    do_reset('0);

    // T2: engine 2 alone hits the outstanding limit
    for (int k = 0; k < 4; k++) exp_ar_q.push_back(ar_item(2));
    base = ar_hs_cnt;
    eng_arvalid = 8'h04;
    tick(8);
    repeat (3) begin
      @(negedge clk);
      chk("t2_blocked", 64'(eng_arready), 64'(0));
    end
    chk("t2_ar_count", 64'(ar_hs_cnt - base), 64'(4));
    chk("t2_busy", 64'(o_busy), 64'(1));
    exp_ar_q.push_back(ar_item(2));
    exp_r_q.push_back(r_item(2, 1'b1, beat_of(2, 0)));
    tick(1);
    eng_rready = 8'h04;
    host_beat(5'd2, beat_of(2, 0), 1'b1);
    eng_rready = '0;
    @(negedge clk);
    chk("t2_regrant", 64'(eng_arready), 64'(8'h04));
    tick(1);
    eng_arvalid = '0;
    tick(3);
    chk("t2_ar_count5", 64'(ar_hs_cnt - base), 64'(5));
    wait_drain("t2_drain", 20);
    do_reset('0);
    exp_ar_q.push_back(ar_item(2));
    eng_arvalid = 8'h04;
    @(negedge clk);
    chk("t2_after_reset", 64'(eng_arready), 64'(8'h04));
    tick(1);
    eng_arvalid = '0;
    wait_drain("t2_reset_drain", 20);
    do_reset('0);

    // T3: host stalls AR with engines 1 and 5 pending
    exp_ar_q.push_back(ar_item(1));
    exp_ar_q.push_back(ar_item(5));
    m_axi_arready = 1'b0;
    eng_arvalid = 8'h22;
    tick(1);
    eng_arvalid = 8'h20;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("t3_arvalid", 64'(m_axi_arvalid), 64'(1));
      chk("t3_arid", 64'(m_axi_arid), 64'(1));
      chk("t3_araddr", 64'(m_axi_araddr), 64'(addr_of(1)));
      chk("t3_arlen", 64'(m_axi_arlen), 64'(len_of(1)));
      chk("t3_no_grant", 64'(eng_arready), 64'(0));
    end
    tick(1);
    m_axi_arready = 1'b1;
    @(negedge clk);
    chk("t3_grant5", 64'(eng_arready), 64'(8'h20));
    tick(1);
    eng_arvalid = '0;
    wait_drain("t3_drain", 20);
    do_reset('0);

    // T4: two bursts to engine 6, 4-beat burst with toggling rready
    exp_ar_q.push_back(ar_item(6));
    exp_ar_q.push_back(ar_item(6));
    eng_arvalid = 8'h40;
    tick(2);
    eng_arvalid = '0;
    wait_drain("t4_ar_drain", 20);
    for (int b = 0; b < 4; b++) exp_r_q.push_back(r_item(6, b == 3, beat_of(6, b)));
    m_axi_rid = 5'd6;
    for (int b = 0; b < 4; b++) begin
      m_axi_rdata  = beat_of(6, b);
      m_axi_rlast  = (b == 3);
      m_axi_rvalid = 1'b1;
      hs = 1'b0;
      while (!hs) begin
        eng_rready[6] = ~eng_rready[6];
        @(negedge clk);
        chk("t4_rready_follow", 64'(m_axi_rready), 64'(eng_rready[6]));
        chk("t4_rvalid_route", 64'(eng_rvalid), 64'(8'h40));
        hs = eng_rready[6];
        tick(1);
      end
    end
    m_axi_rvalid = 1'b0;
    m_axi_rlast  = 1'b0;
    eng_rready   = '0;
    @(negedge clk);
    chk("t4_busy_one_left", 64'(o_busy), 64'(1));
    exp_r_q.push_back(r_item(6, 1'b1, beat_of(6, 9)));
    tick(1);
    eng_rready = 8'h40;
    host_beat(5'd6, beat_of(6, 9), 1'b1);
    eng_rready = '0;
    @(negedge clk);
    chk("t4_busy_cleared", 64'(o_busy), 64'(0));
    wait_drain("t4_drain", 20);
    do_reset('0);

    // T5: grant and last beat for engine 3 in the same cycle
    exp_ar_q.push_back(ar_item(3));
    eng_arvalid = 8'h08;
    tick(1);
    eng_arvalid = '0;
    tick(2);
    for (int k = 0; k < 4; k++) exp_ar_q.push_back(ar_item(3));
    exp_r_q.push_back(r_item(3, 1'b1, beat_of(3, 0)));
    base = ar_hs_cnt;
    eng_arvalid  = 8'h08;
    eng_rready   = 8'h08;
    m_axi_rid    = 5'd3;
    m_axi_rdata  = beat_of(3, 0);
    m_axi_rlast  = 1'b1;
    m_axi_rvalid = 1'b1;
    @(negedge clk);
    chk("t5_same_cycle_grant", 64'(eng_arready), 64'(8'h08));
    tick(1);
    m_axi_rvalid = 1'b0;
    m_axi_rlast  = 1'b0;
    eng_rready   = '0;
    tick(8);
    eng_arvalid = '0;
    tick(2);
    chk("t5_ar_count", 64'(ar_hs_cnt - base), 64'(4));
    wait_drain("t5_drain", 20);
    do_reset('0);

    // T6: unmapped RIDs are swallowed and flagged
    eng_rready   = '1;
    m_axi_rid    = 5'h1F;
    m_axi_rdata  = beat_of(0, 7);
    m_axi_rlast  = 1'b1;
    m_axi_rvalid = 1'b1;
    @(negedge clk);
    chk("t6_rready", 64'(m_axi_rready), 64'(1));
    chk("t6_no_rvalid", 64'(eng_rvalid), 64'(0));
    chk("t6_err_before", 64'(o_rid_err), 64'(0));
    tick(1);
    m_axi_rvalid = 1'b0;
    eng_rready   = '0;
    @(negedge clk);
    chk("t6_err_set", 64'(o_rid_err), 64'(1));
    tick(5);
    chk("t6_err_sticky", 64'(o_rid_err), 64'(1));
    do_reset('0);
    m_axi_rid    = 5'h0A;
    m_axi_rvalid = 1'b1;
    @(negedge clk);
    chk("t6_hi_rid_rready", 64'(m_axi_rready), 64'(1));
    chk("t6_hi_rid_rvalid", 64'(eng_rvalid), 64'(0));
    tick(1);
    m_axi_rid = 5'h05;
    @(negedge clk);
    chk("t6_in_range_rready", 64'(m_axi_rready), 64'(0));
    chk("t6_in_range_rvalid", 64'(eng_rvalid), 64'(8'h20));
    chk("t6_hi_rid_err", 64'(o_rid_err), 64'(1));
    tick(1);
    m_axi_rvalid = 1'b0;
    do_reset('0);

    chk("end_ar_q_empty", 64'(exp_ar_q.size()), 64'(0));
    chk("end_r_q_empty", 64'(exp_r_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
